// File: rtl/aurora_multi_ch_tx.sv
// Multi-channel Aurora AXI4-Stream transmitter: arbitrates NUM_CH packet FIFOs, prepends an
// 8-bit channel header and serialises each packet into TX_TDATA_SIZE-bit beats.
module aurora_multi_ch_tx #(
   parameter int unsigned PACKET_SIZE   = 128,
   parameter int unsigned TX_TDATA_SIZE = 32,
   parameter int unsigned COUNTER_BITS  = 2,
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned CH_BITS       = 2,
   parameter int unsigned ARB_MODE      = 0
) (
   input  logic                             user_clk,
   input  logic                             RST,
   input  logic                             start,
   input  logic [NUM_CH-1:0]                fifo_empty,
   input  logic [NUM_CH*(PACKET_SIZE-8)-1:0] fifo_dout,
   output logic [NUM_CH-1:0]                fifo_rd_en,
   input  logic                             s_axi_tx_tready,
   output logic                             s_axi_tx_tvalid,
   output logic                             s_axi_tx_tlast,
   output logic [0:TX_TDATA_SIZE-1]         s_axi_tx_tdata,
   output logic                             busy,
   output logic [15:0]                      tx_pkt_cnt
);

   localparam int unsigned BEATS = PACKET_SIZE / TX_TDATA_SIZE;
   localparam int unsigned PAY   = PACKET_SIZE - 8;

   typedef enum logic [1:0] {StIdle, StRd, StCap, StSend} state_t;

   state_t                  r_state, w_state_nxt;
   logic [CH_BITS-1:0]      r_grant, r_rr_ptr, w_sel;
   logic                    w_found;
   logic [COUNTER_BITS-1:0] r_beat_cnt;
   logic [PACKET_SIZE-1:0]  r_shift;
   logic [15:0]             r_pkt_cnt;
   logic                    w_last, w_fire;
   int unsigned             w_idx;

   // Search order starts at rr_ptr in round-robin mode, at index 0 in fixed-priority mode.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (ARB_MODE == 1) w_idx = i;
         else               w_idx = (32'(r_rr_ptr) + i) % NUM_CH;
         if (!w_found && !fifo_empty[w_idx[CH_BITS-1:0]]) begin
            w_found = 1'b1;
            w_sel   = w_idx[CH_BITS-1:0];
         end
      end
   end

   assign w_last = (r_beat_cnt == COUNTER_BITS'(BEATS - 1));
   assign w_fire = (r_state == StSend) && s_axi_tx_tready;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (start && w_found) w_state_nxt = StRd;
         StRd:    w_state_nxt = StCap;
         StCap:   w_state_nxt = StSend;
         StSend:  if (w_fire && w_last) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      fifo_rd_en = '0;
      if (r_state == StRd) fifo_rd_en[r_grant] = 1'b1;
      s_axi_tx_tvalid = (r_state == StSend);
      s_axi_tx_tlast  = (r_state == StSend) && w_last;
      s_axi_tx_tdata  = (r_state == StSend) ? r_shift[PACKET_SIZE-1 -: TX_TDATA_SIZE] : '0;
      busy            = (r_state != StIdle);
      tx_pkt_cnt      = r_pkt_cnt;
   end

   always_ff @(posedge user_clk) begin
      if (!RST) begin
         r_state    <= StIdle;
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
         r_shift    <= '0;
         r_pkt_cnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == StIdle && start && w_found) r_grant <= w_sel;
         if (r_state == StCap) begin
            r_shift    <= {8'(r_grant), fifo_dout[32'(r_grant)*PAY +: PAY]};
            r_beat_cnt <= '0;
         end
         if (w_fire) begin
            r_shift    <= r_shift << TX_TDATA_SIZE;
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_last) begin
               r_pkt_cnt <= r_pkt_cnt + 16'd1;
               r_rr_ptr  <= (r_grant == CH_BITS'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aurora_multi_ch_tx.sv
// Directed bench: FIFO + packet-stream model checked every cycle, plus literal spot values.
module tb_aurora_multi_ch_tx;
   localparam int P = 128, W = 32, NCH = 4, PAY = 120, BEATS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1, start, tready, sel;
   logic [NCH-1:0]     fifo_empty;
   logic [NCH*PAY-1:0] fifo_dout;
   logic [NCH-1:0]     rd_en0, rd_en1, m_rd_en;
   logic               tv0, tv1, tl0, tl1, busy0, busy1, m_tv, m_tl, m_busy, m_rst;
   logic [0:W-1]       td0, td1, m_td;
   logic [15:0]        cnt0, cnt1, m_cnt;

   aurora_multi_ch_tx #(.ARB_MODE(0)) u_rr (
      .user_clk(clk), .RST(rst0), .start(start), .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout), .fifo_rd_en(rd_en0), .s_axi_tx_tready(tready),
      .s_axi_tx_tvalid(tv0), .s_axi_tx_tlast(tl0), .s_axi_tx_tdata(td0),
      .busy(busy0), .tx_pkt_cnt(cnt0));

   aurora_multi_ch_tx #(.ARB_MODE(1)) u_fp (
      .user_clk(clk), .RST(rst1), .start(start), .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout), .fifo_rd_en(rd_en1), .s_axi_tx_tready(tready),
      .s_axi_tx_tvalid(tv1), .s_axi_tx_tlast(tl1), .s_axi_tx_tdata(td1),
      .busy(busy1), .tx_pkt_cnt(cnt1));

   assign m_rd_en = sel ? rd_en1 : rd_en0;
   assign m_tv    = sel ? tv1 : tv0;
   assign m_tl    = sel ? tl1 : tl0;
   assign m_td    = sel ? td1 : td0;
   assign m_busy  = sel ? busy1 : busy0;
   assign m_cnt   = sel ? cnt1 : cnt0;
   assign m_rst   = sel ? rst1 : rst0;

   // FIFO model: pushes from stimulus, pops on the selected DUT's rd_en.
   logic [PAY-1:0] mem [NCH][16];
   logic [PAY-1:0] dout_r [NCH];
   int push_n [NCH];
   int pop_n  [NCH];

   always_comb begin
      fifo_empty = '0;
      fifo_dout  = '0;
      for (int c = 0; c < NCH; c++) begin
         fifo_empty[c] = (push_n[c] == pop_n[c]);
         fifo_dout[c*PAY +: PAY] = dout_r[c];
      end
   end

   logic [P-1:0] exp_pkt [64];
   int exp_wr, exp_rd, bcnt, model_cnt, rd_seen, n_pass, n_tot;
   bit inflight, prev_stall, prev_rd, prev_tl;
   logic [W-1:0] prev_td;
   logic [W-1:0] beat_log [$];
   bit last_log [$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   function automatic logic [PAY-1:0] payload(input int c, input int k);
      logic [7:0] b;
      b = 8'(17 * (c + 1) + k);
      return {8'(c), 8'(k), {13{b}}};
   endfunction

   task automatic push(input int c, input logic [PAY-1:0] d);
      mem[c][push_n[c] % 16] = d;
      push_n[c]++;
      exp_pkt[exp_wr] = {8'(c), d};
      exp_wr++;
   endtask

   // Per-cycle compare, sampled at the falling edge.
   task automatic step();
      logic [W-1:0] tdv;
      int ch;
      tdv = m_td;
      if (!m_rst) begin
         if (inflight) exp_rd++;
         inflight = 0; bcnt = 0; model_cnt = 0; prev_stall = 0; prev_rd = 0;
         return;
      end
      chk("pkt_cnt", m_cnt, 16'(model_cnt));
      chk("rd_onehot", ($countones(m_rd_en) <= 1), 1);
      chk("rd_with_tvalid", (|m_rd_en) & m_tv, 0);
      if ((|m_rd_en) || m_tv) chk("busy", m_busy, 1);
      if (prev_rd) chk("rd_pulse", |m_rd_en, 0);
      if (prev_stall) begin
         chk("hold_tvalid", m_tv, 1);
         chk("hold_tdata", tdv, prev_td);
         chk("hold_tlast", m_tl, prev_tl);
      end
      if (|m_rd_en) begin
         ch = -1;
         for (int c = 0; c < NCH; c++) if (m_rd_en[c] && ch < 0) ch = c;
         chk("rd_nonempty", fifo_empty[ch], 0);
         if (exp_rd < exp_wr) chk("grant_ch", ch, exp_pkt[exp_rd][P-1 -: 8]);
         else chk("rd_unexpected", m_rd_en, 0);
         dout_r[ch] = mem[ch][pop_n[ch] % 16];
         pop_n[ch]++;
         inflight = 1;
         rd_seen++;
      end
      if (m_tv) begin
         if (exp_rd < exp_wr) begin
            chk("tdata", tdv, exp_pkt[exp_rd][P-1-W*bcnt -: W]);
            chk("tlast", m_tl, (bcnt == BEATS - 1));
         end else chk("tvalid_unexpected", m_tv, 0);
         if (tready) begin
            beat_log.push_back(tdv);
            last_log.push_back(m_tl);
            bcnt++;
            if (bcnt == BEATS) begin
               bcnt = 0; exp_rd++; inflight = 0;
               model_cnt = (model_cnt + 1) & 16'hFFFF;
            end
         end
      end
      prev_stall = m_tv && !tready;
      prev_td    = tdv;
      prev_tl    = m_tl;
      prev_rd    = |m_rd_en;
   endtask

   task automatic cycle();
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until(input string nm, input int target, input int limit);
      int n = 0;
      while (exp_rd < target && n < limit) begin
         cycle();
         n++;
      end
      chk(nm, exp_rd, target);
   endtask

   task automatic do_reset(input bit which);
      rst0 = 1'b0; rst1 = 1'b0;
      repeat (3) cycle();
      sel = which;
      if (which) rst1 = 1'b1; else rst0 = 1'b1;
      beat_log.delete();
      last_log.delete();
   endtask

   logic [63:0] hs;
   int pat [4] = '{1, 0, 0, 1};
   int r0, n;

   initial begin
      sel = 0; rst0 = 0; rst1 = 0; start = 0; tready = 1;
      exp_wr = 0; exp_rd = 0; bcnt = 0; model_cnt = 0; rd_seen = 0; n_pass = 0; n_tot = 0;
      inflight = 0; prev_stall = 0; prev_rd = 0; prev_tl = 0; prev_td = '0;
      for (int c = 0; c < NCH; c++) begin push_n[c] = 0; pop_n[c] = 0; dout_r[c] = '0; end

      // Reset state
      do_reset(0);
      chk("rst_tvalid", m_tv, 0);
      chk("rst_tlast", m_tl, 0);
      chk("rst_tdata", m_td, 0);
      chk("rst_rd_en", m_rd_en, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_cnt", m_cnt, 0);

      // Single packet on ch2, latency and beat content
      start = 1;
      push(2, 120'h0102030405060708090A0B0C0D0E0F);
      cycle(); chk("t1_rd_en", m_rd_en, 4'b0100);
      cycle(); chk("t1_cap_tvalid", m_tv, 0);
      cycle(); chk("t1_tvalid", m_tv, 1); chk("t1_beat0_live", m_td, 32'h02010203);
      run_until("t1_done", exp_wr, 20);
      chk("t1_nbeats", beat_log.size(), 4);
      chk("t1_beat0", beat_log[0], 32'h02010203);
      chk("t1_beat3", beat_log[3], 32'h0C0D0E0F);
      chk("t1_tlast", {last_log[0], last_log[1], last_log[2], last_log[3]}, 4'b0001);
      chk("t1_cnt", m_cnt, 1);

      // Round-robin over all four channels, two packets each
      do_reset(0);
      for (int k = 0; k < 2; k++) for (int c = 0; c < NCH; c++) push(c, payload(c, k));
      run_until("t2_done", exp_wr, 120);
      chk("t2_nbeats", beat_log.size(), 32);
      hs = '0;
      for (int i = 0; i < 8; i++) hs = {hs[55:0], beat_log[4*i][31:24]};
      chk("t2_hdr_order", hs, 64'h00010203_00010203);
      chk("t2_cnt", m_cnt, 8);

      // Fixed priority: ch0 drains before ch3
      do_reset(1);
      for (int k = 0; k < 3; k++) begin push(0, payload(0, k)); end
      for (int k = 0; k < 3; k++) begin push(3, payload(3, k)); end
      run_until("t3_done", exp_wr, 100);
      hs = '0;
      for (int i = 0; i < 6; i++) hs = {hs[55:0], beat_log[4*i][31:24]};
      chk("t3_hdr_order", hs, 64'h0000_000000_030303);
      chk("t3_cnt", m_cnt, 6);

      // Backpressure
      do_reset(0);
      push(1, payload(1, 5));
      n = 0;
      while (exp_rd < exp_wr && n < 100) begin
         tready = pat[n % 4][0];
         cycle();
         n++;
      end
      tready = 1;
      chk("t4_done", exp_rd, exp_wr);
      chk("t4_nbeats", beat_log.size(), 4);
      chk("t4_beat0", beat_log[0], 32'h01010527);
      chk("t4_beat1", beat_log[1], 32'h27272727);
      chk("t4_cnt", m_cnt, 1);

      // start drops after beat1
      do_reset(0);
      push(0, payload(0, 1));
      push(1, payload(1, 1));
      r0 = exp_rd;
      n = 0;
      while (!(bcnt >= 2) && n < 50) begin cycle(); n++; end
      start = 0;
      run_until("t5_first_done", r0 + 1, 20);
      r0 = rd_seen;
      repeat (10) cycle();
      chk("t5_no_rd", rd_seen, r0);
      chk("t5_idle", m_busy, 0);
      chk("t5_cnt1", m_cnt, 1);
      start = 1;
      run_until("t5_done", exp_wr, 30);
      chk("t5_cnt2", m_cnt, 2);

      // Reset while beat2 is presented
      do_reset(0);
      push(3, payload(3, 0));
      push(3, payload(3, 1));
      n = 0;
      while (!(bcnt >= 2) && n < 50) begin cycle(); n++; end
      chk("t6_at_beat2", m_td, 32'h44444444);
      rst0 = 0;
      cycle();
      rst0 = 1;
      chk("t6_rst_tvalid", m_tv, 0);
      chk("t6_rst_busy", m_busy, 0);
      chk("t6_rst_cnt", m_cnt, 0);
      run_until("t6_done", exp_wr, 30);
      chk("t6_nbeats", beat_log.size(), 6);
      chk("t6_restart_beat0", beat_log[2], 32'h03030145);
      chk("t6_cnt", m_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
